spi_chip_responder: RTL and testbench
=====================================

# spi_chip_responder

FPGA-side responder for the two-wire SPI link (pico/spi_clk out, poci back) driven by the FPGA SPI write controller. It oversamples spi_clk on the FPGA clock, decodes 16-bit address/data frames, and maintains an 8 x 8-bit register file mirroring the chip's configuration registers. It drives read-back data on poci, which supports closed-loop testing of the controller without silicon. It also serves as the register model behind the board's chip emulator.

## Interface
- SYNC_STAGES, 2, flip-flop stages on spi_clk and pico before edge detection; minimum 2
- IDLE_TIMEOUT, 64, clk cycles without a spi_clk rising edge before a partial frame is discarded
- clk  input  1  FPGA system clock; all logic on its rising edge
- rstn  input  1  asynchronous active-low reset
- spi_clk  input  1  serial clock from the controller; idles low; asynchronous to clk
- pico  input  1  serial data from the controller; MSB first
- poci  output  1  serial read-back data to the controller
- reg_file  output  64  registers 0..7 flattened; register n occupies bits [8n+7:8n]
- write_strobe  output  1  one-cycle pulse when a register is written
- write_addr  output  3  index of the written register; valid with write_strobe
- frame_error  output  1  one-cycle pulse when a partial frame times out
- busy  output  1  high while a frame is in progress (bit count nonzero)

## Operation
- Frame: 8-bit address, then 8-bit data, 16 spi_clk rising edges total, MSB first. Bits are sampled on the synchronized rising edge of spi_clk. The link has no chip select; framing is by bit count and timeout only.
- Edge detect: compare the last two synchronized spi_clk samples. The pico sample is taken from the same synchronizer depth, so both signals see equal latency.
- Bit counter: 0..15. It increments on each rising edge and wraps to 0 after bit 15.
- Address map:
  - 0x00–0x07: read/write register n.
  - 0x08–0x0F: read-only alias of register (addr-8). Write data is ignored.
  - 0x10–0xFF: unmapped. Returns 0x00, no write.
- After the 8th rising edge (address complete), load the shift-out register:
  - With the current contents of the addressed register, giving read-before-write semantics.
  - With 0x00 if the address is unmapped.
  - Drive its MSB on poci immediately.
- On each synchronized falling edge during the data phase, shift the next bit onto poci. After the data phase, poci returns to 0.
- poci is 0 during the address phase and while idle.
- On the 16th rising edge with address 0x00–0x07:
  - Register [addr[2:0]] takes the received data byte.
  - write_strobe is high for one cycle, with write_addr = addr[2:0].
- Timeout: a counter clears on every rising edge and counts while busy. When it reaches IDLE_TIMEOUT:
  - The bit counter clears.
  - poci goes to 0 and frame_error pulses once.
  - No register changes.
  - The timeout counter saturates and does not count while idle.
- Simultaneous events: a timeout and a rising edge in the same cycle resolve in favour of the edge (counter clears, bit is accepted).

## Timing
- Reset values: reg_file = 0, poci = 0, write_strobe = 0, write_addr = 0, frame_error = 0, busy = 0. Synchronizers, counters and the shift registers all clear.
- Reset mid-frame aborts the frame with no write. The first rising edge after release is bit 0.
- Edge detection latency is SYNC_STAGES+1 clk cycles from the pin.
- write_strobe and the reg_file update occur in the same clk cycle, SYNC_STAGES+1 cycles after the 16th spi_clk rising edge.
- poci's first data bit is valid SYNC_STAGES+2 clk cycles after the 8th rising edge. Each later bit is valid SYNC_STAGES+2 cycles after the corresponding falling edge.
- Requirement on spi_clk: each high and low phase must be at least SYNC_STAGES+3 clk cycles (10 clk per spi_clk period at the default). The bench checks this against the controller's divider.
- Back-to-back frames need no gap; bit 0 of the next frame may follow bit 15 immediately.

## Test plan
- Write 0xAA to address 0x01 after reset:
  - reg 1 = 0xAA.
  - write_strobe pulses once with write_addr = 1.
  - poci returns 0x00 during the data phase.
- Write 0x02 to address 0x01, then 0x55 to address 0x07:
  - poci returns 0xAA on the first frame.
  - reg 1 = 0x02, reg 7 = 0x55.
  - All other registers stay 0.
- Frame with address 0x09, data 0xFF:
  - poci returns 0x02.
  - No write_strobe; reg 1 unchanged.
- Address 0x20, data 0x5A:
  - poci returns 0x00.
  - No write_strobe; reg_file unchanged.
- Send 5 bits, then hold spi_clk low for 64 clk:
  - frame_error pulses once, busy falls.
  - The next full frame writing 0x3C to address 0x02 succeeds.
- Assert rstn after the 12th bit of a write to 0x03:
  - All outputs are at reset values and reg 3 = 0x00.
  - A following full frame to 0x03 writes correctly.

Source files
------------

// File: rtl/spi_chip_responder.sv
// SPI register-file responder: oversamples spi_clk/pico on clk, decodes 16-bit
// address/data frames into an 8 x 8-bit register file and shifts read-back data on poci.
module spi_chip_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_clk,
    input  logic        pico,
    output logic        poci,
    output logic [63:0] reg_file,
    output logic        write_strobe,
    output logic [2:0]  write_addr,
    output logic        frame_error,
    output logic        busy
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] pico_sync_q, pico_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_in_q, shift_in_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             shift_out_q, shift_out_d;
    logic                   poci_q, poci_d;
    logic [63:0]            reg_file_q, reg_file_d;
    logic                   write_strobe_q, write_strobe_d;
    logic [2:0]             write_addr_q, write_addr_d;
    logic                   frame_error_q, frame_error_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;

    logic       sclk_s, pico_s, rise, fall, busy_w;
    logic [7:0] rx_byte, load_byte;
    logic [5:0] rd_sel, wr_sel;

    // spi_clk and pico take equal synchronizer depth so each sampled bit lines up with its edge
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign pico_s  = pico_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;
    assign busy_w  = (bit_cnt_q != 4'd0);
    assign rx_byte = {shift_in_q[6:0], pico_s};
    assign rd_sel  = {rx_byte[2:0], 3'b000};
    assign wr_sel  = {addr_q[2:0], 3'b000};
    assign load_byte = (rx_byte[7:4] == 4'd0) ? reg_file_q[rd_sel +: 8] : 8'h00;

    always_comb begin
        sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        pico_sync_d    = {pico_sync_q[SYNC_STAGES-2:0], pico};
        sclk_prev_d    = sclk_s;
        bit_cnt_d      = bit_cnt_q;
        shift_in_d     = shift_in_q;
        addr_d         = addr_q;
        shift_out_d    = shift_out_q;
        poci_d         = poci_q;
        reg_file_d     = reg_file_q;
        write_strobe_d = 1'b0;
        write_addr_d   = write_addr_q;
        frame_error_d  = 1'b0;
        to_cnt_d       = to_cnt_q;

        if (rise) begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shift_in_d = rx_byte;
            to_cnt_d   = '0;
            if (bit_cnt_q == 4'd7) begin
                // Read-before-write: shift-out captures the register before this frame's write
                addr_d      = rx_byte;
                shift_out_d = load_byte;
                poci_d      = load_byte[7];
            end
            if (bit_cnt_q == 4'd15) begin
                poci_d = 1'b0;
                if (addr_q[7:3] == 5'd0) begin
                    reg_file_d[wr_sel +: 8] = rx_byte;
                    write_strobe_d          = 1'b1;
                    write_addr_d            = addr_q[2:0];
                end
            end
        end else begin
            if (fall && bit_cnt_q[3]) begin
                shift_out_d = {shift_out_q[6:0], 1'b0};
                poci_d      = shift_out_q[6];
            end
            if (busy_w && to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_cnt_q == TO_LAST) begin
                    bit_cnt_d     = 4'd0;
                    poci_d        = 1'b0;
                    frame_error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_q    <= '0;
            pico_sync_q    <= '0;
            sclk_prev_q    <= 1'b0;
            bit_cnt_q      <= 4'd0;
            shift_in_q     <= 8'h00;
            addr_q         <= 8'h00;
            shift_out_q    <= 8'h00;
            poci_q         <= 1'b0;
            reg_file_q     <= 64'h0;
            write_strobe_q <= 1'b0;
            write_addr_q   <= 3'd0;
            frame_error_q  <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            pico_sync_q    <= pico_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_in_q     <= shift_in_d;
            addr_q         <= addr_d;
            shift_out_q    <= shift_out_d;
            poci_q         <= poci_d;
            reg_file_q     <= reg_file_d;
            write_strobe_q <= write_strobe_d;
            write_addr_q   <= write_addr_d;
            frame_error_q  <= frame_error_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign poci         = poci_q;
    assign reg_file     = reg_file_q;
    assign write_strobe = write_strobe_q;
    assign write_addr   = write_addr_q;
    assign frame_error  = frame_error_q;
    assign busy         = busy_w;

endmodule

// File: tb/tb_spi_chip_responder.sv
// Directed bench for spi_chip_responder: bit-bangs SPI frames and checks
// register file, strobes, poci read-back, timeout and mid-frame reset.
module tb_spi_chip_responder;

    localparam int HALF = 6;
    localparam int IDLE_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_clk = 1'b0;
    logic        pico = 1'b0;
    logic        poci;
    logic [63:0] reg_file;
    logic        write_strobe;
    logic [2:0]  write_addr;
    logic        frame_error;
    logic        busy;

    int total = 0;
    int bad = 0;
    int ws_cnt = 0;
    int fe_cnt = 0;
    logic [2:0] last_wa = 3'd0;

    spi_chip_responder #(.SYNC_STAGES(2), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .pico(pico), .poci(poci),
        .reg_file(reg_file), .write_strobe(write_strobe), .write_addr(write_addr),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_strobe) begin
            ws_cnt <= ws_cnt + 1;
            last_wa <= write_addr;
        end
        if (frame_error) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sends n bits of word MSB first; poci is sampled just before each falling
    // edge of frame bits 7..14, which carry read-back bits 7..0.
    task automatic send_bits(input logic [15:0] word, input int n, output logic [7:0] rd);
        rd = 8'h00;
        for (int b = 0; b < n; b++) begin
            pico = word[15-b];
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (b >= 7 && b <= 14) rd[14-b] = poci;
            else if (b < 7) check("poci_addr_phase", {63'd0, poci}, 64'd0);
            spi_clk = 1'b0;
        end
        pico = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] data, output logic [7:0] rd);
        send_bits({addr, data}, 16, rd);
        repeat (HALF + 4) @(negedge clk);
    endtask

    logic [7:0] rd;
    int ws_base, fe_base;

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_reg_file", reg_file, 64'h0);
        check("rst_poci", {63'd0, poci}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_strobe", {63'd0, write_strobe}, 64'd0);
        check("rst_waddr", {61'd0, write_addr}, 64'd0);
        check("rst_ferr", {63'd0, frame_error}, 64'd0);

        ws_base = ws_cnt;
        send_frame(8'h01, 8'hAA, rd);
        check("w1_readback", {56'd0, rd}, 64'h00);
        check("w1_reg_file", reg_file, 64'h0000_0000_0000_AA00);
        check("w1_strobes", ws_cnt - ws_base, 1);
        check("w1_waddr", {61'd0, last_wa}, 64'd1);
        check("w1_busy", {63'd0, busy}, 64'd0);
        check("w1_poci_idle", {63'd0, poci}, 64'd0);

        ws_base = ws_cnt;
        send_frame(8'h01, 8'h02, rd);
        check("w2_readback", {56'd0, rd}, 64'hAA);
        send_frame(8'h07, 8'h55, rd);
        check("w3_readback", {56'd0, rd}, 64'h00);
        check("w3_reg_file", reg_file, 64'h5500_0000_0000_0200);
        check("w3_strobes", ws_cnt - ws_base, 2);
        check("w3_waddr", {61'd0, last_wa}, 64'd7);

        ws_base = ws_cnt;
        send_frame(8'h09, 8'hFF, rd);
        check("alias_readback", {56'd0, rd}, 64'h02);
        check("alias_reg_file", reg_file, 64'h5500_0000_0000_0200);
        check("alias_strobes", ws_cnt - ws_base, 0);

        send_frame(8'h20, 8'h5A, rd);
        check("unmap_readback", {56'd0, rd}, 64'h00);
        check("unmap_reg_file", reg_file, 64'h5500_0000_0000_0200);
        check("unmap_strobes", ws_cnt - ws_base, 0);

        fe_base = fe_cnt;
        send_bits({8'hA5, 8'h00}, 5, rd);
        repeat (40) @(negedge clk);
        check("part_busy_early", {63'd0, busy}, 64'd1);
        check("part_ferr_early", fe_cnt - fe_base, 0);
        repeat (IDLE_TIMEOUT) @(negedge clk);
        check("part_ferr", fe_cnt - fe_base, 1);
        check("part_busy", {63'd0, busy}, 64'd0);
        check("part_poci", {63'd0, poci}, 64'd0);
        send_frame(8'h02, 8'h3C, rd);
        check("post_to_readback", {56'd0, rd}, 64'h00);
        check("post_to_reg_file", reg_file, 64'h5500_0000_003C_0200);
        check("post_to_waddr", {61'd0, last_wa}, 64'd2);
        check("post_to_ferr", fe_cnt - fe_base, 1);

        send_bits({8'h03, 8'h99}, 12, rd);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_reg_file", reg_file, 64'h0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_poci", {63'd0, poci}, 64'd0);
        check("midrst_strobe", {63'd0, write_strobe}, 64'd0);
        check("midrst_waddr", {61'd0, write_addr}, 64'd0);
        check("midrst_ferr", {63'd0, frame_error}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        ws_base = ws_cnt;
        send_frame(8'h03, 8'h77, rd);
        check("after_rst_readback", {56'd0, rd}, 64'h00);
        check("after_rst_reg_file", reg_file, 64'h0000_0000_7700_0000);
        check("after_rst_strobes", ws_cnt - ws_base, 1);
        check("after_rst_waddr", {61'd0, last_wa}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
